fir_mac_sequencer: RTL and testbench

Serial single-MAC FIR engine controller. It sequences a 32-entry combinational coefficient ROM through one multiply-accumulate per tap, and keeps the 32-sample delay line internally. The coefficient ROM is the 5-bit address, 16-bit signed Q15 coefficient ROM used by the filter path. The block sits between the sample source (ADC/decimator strobe) and the output path, producing one filtered sample per accepted input sample.

---
 rtl/fir_mac_sequencer.sv | 119 +++++++++++
 tb/tb_fir_mac_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - serial single-MAC FIR sequencer with internal delay line
// One multiply-accumulate per tap against an external combinational coefficient ROM.
module fir_mac_sequencer #(
  parameter int DW    = 16,
  parameter int TAPS  = 32,
  parameter int AW    = 5,
  parameter int ACC_W = 40,
  parameter int SHIFT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] x_in,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic                 clr,
  output logic [AW-1:0]        coef_addr,
  input  logic signed [DW-1:0] coef_in,
  output logic signed [DW-1:0] y_out,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam logic signed [ACC_W-1:0] MAX_Y = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_Y = ACC_W'(-(2 ** (DW - 1)));

  state_t state, next_state;

  logic                    clear;
  logic                    accept;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           newest;
  logic [AW-1:0]           tap;
  logic signed [DW-1:0]    hist [TAPS];
  logic signed [DW-1:0]    sample;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic signed [DW-1:0]    sat_y;

  assign clear = rst | clr;

  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    x_ready    = 1'b0;
    busy       = 1'b0;
    coef_addr  = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        x_ready = 1'b1;
        if (x_valid) begin
          accept     = 1'b1;
          next_state = MAC;
        end
      end
      MAC: begin
        busy      = 1'b1;
        coef_addr = tap;
        if (tap == AW'(TAPS - 1)) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Pointer difference wraps modulo TAPS because TAPS == 2**AW.
  assign sample  = hist[newest - tap];
  assign prod    = coef_in * sample;
  assign shifted = acc >>> SHIFT;

  always_comb begin
    sat_y = shifted[DW-1:0];
    if (shifted > MAX_Y)      sat_y = MAX_Y[DW-1:0];
    else if (shifted < MIN_Y) sat_y = MIN_Y[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < TAPS; i++) hist[i] <= '0;
      wr_ptr  <= '0;
      newest  <= '0;
      tap     <= '0;
      acc     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (x_valid && !x_ready) overrun <= 1'b1;
      if (accept) begin
        hist[wr_ptr] <= x_in;
        newest       <= wr_ptr;
        wr_ptr       <= wr_ptr + AW'(1);
        acc          <= '0;
        tap          <= '0;
      end
      if (state == MAC) begin
        acc <= acc + {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};
        tap <= tap + AW'(1);
      end
      if (state == DONE) begin
        y_out   <= sat_y;
        y_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - scoreboard bench for fir_mac_sequencer
module tb_fir_mac_sequencer;

  logic               clk = 1'b0;
  logic               rst, clr, x_valid;
  logic               x_ready, y_valid, busy, overrun;
  logic signed [15:0] x_in, coef_in, y_out;
  logic [4:0]         coef_addr;
  logic signed [15:0] rom [32];
  int                 cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb coef_in = rom[coef_addr];

  fir_mac_sequencer dut (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .clr(clr), .coef_addr(coef_addr), .coef_in(coef_in), .y_out(y_out),
    .y_valid(y_valid), .busy(busy), .overrun(overrun)
  );

  typedef struct {int y; int cyc;} exp_t;
  exp_t expq[$];
  exp_t e;
  int   outs[$];
  int   mh[32];
  int   mptr;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   prev_yv = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int x);
    longint acc, q;
    int nw;
    mh[mptr] = x;
    nw = mptr;
    mptr = (mptr + 1) % 32;
    acc = 0;
    for (int k = 0; k < 32; k++) acc += longint'(rom[k]) * longint'(mh[(nw - k + 32) % 32]);
    q = acc >>> 15;
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mh[i] = 0;
    mptr = 0;
    expq.delete();
    outs.delete();
  endtask

  always @(negedge clk) begin
    if (y_valid) begin
      chk("y_valid_back2back", int'(prev_yv), 0);
      if (expq.size() == 0) chk("unexpected_y", int'(y_valid), 0);
      else begin
        e = expq.pop_front();
        chk("y_out", int'(y_out), e.y);
        chk("latency", cyc - e.cyc, 34);
        outs.push_back(int'(y_out));
      end
    end
    prev_yv = y_valid;
  end

  task automatic do_reset(input bit use_clr);
    @(negedge clk);
    if (use_clr) clr = 1'b1;
    else         rst = 1'b1;
    x_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
    model_clear();
  endtask

  task automatic send(input int x);
    int n = 0;
    while (!x_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!x_ready) begin
      chk("x_ready_wait", int'(x_ready), 1);
      return;
    end
    x_in    = 16'(x);
    x_valid = 1'b1;
    expq.push_back('{model(x), cyc});
    @(negedge clk);
    x_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", expq.size(), 0);
    expq.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic run_impulse(input string tag);
    outs.delete();
    send(32767);
    for (int i = 0; i < 31; i++) send(0);
    wait_drain();
    chk({tag, "_count"}, outs.size(), 32);
    chk({tag, "_y0"}, outs[0], 48);
    chk({tag, "_y15"}, outs[15], 20809);
    chk({tag, "_y16"}, outs[16], -20810);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int k = 0; k < 16; k++) begin
      rom[k]      = 16'(49 + (20761 * k * k) / 225);
      rom[31 - k] = -rom[k];
    end
    rst = 1'b1; clr = 1'b0; x_valid = 1'b0; x_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();

    chk("rst_x_ready", int'(x_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_y_out", int'(y_out), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_coef_addr", int'(coef_addr), 0);

    run_impulse("impulse");

    do_reset(1'b0);
    for (int i = 0; i < 40; i++) send(32767);
    wait_drain();
    for (int i = 31; i < 40; i++) chk("dc_zero", outs[i], 0);

    do_reset(1'b0);
    for (int i = 0; i < 16; i++) send(-32768);
    for (int i = 0; i < 16; i++) send(32767);
    send(0);
    wait_drain();
    chk("sat_y31", outs[31], 32767);

    do_reset(1'b0);
    send(1234);
    repeat (4) @(negedge clk);
    x_in = 16'sd1000;
    x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_busy", int'(busy), 1);
    wait_drain();
    chk("overrun_held", int'(overrun), 1);
    send(-777);
    wait_drain();
    @(negedge clk);
    clr = 1'b1;
    x_valid = 1'b1;
    x_in = 16'sd5555;
    @(negedge clk);
    clr = 1'b0;
    x_valid = 1'b0;
    model_clear();
    chk("clr_overrun", int'(overrun), 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_y_out", int'(y_out), 0);
    chk("clr_x_ready", int'(x_ready), 1);

    do_reset(1'b0);
    send(32767);
    repeat (9) @(negedge clk);
    chk("abort_tap9", int'(coef_addr), 9);
    chk("abort_busy_pre", int'(busy), 1);
    rst = 1'b1;
    expq.delete();
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_x_ready", int'(x_ready), 1);
    chk("abort_coef_addr", int'(coef_addr), 0);
    rst = 1'b0;
    model_clear();
    repeat (40) @(negedge clk);
    run_impulse("reimpulse");

    do_reset(1'b0);
    c = cyc;
    x_in = 16'sd500;
    x_valid = 1'b1;
    for (int i = 0; i < 3; i++) expq.push_back('{model(500), c + 34 * i});
    for (int i = 0; i <= 68; i++) begin
      chk("hold_x_ready", int'(x_ready), (i % 34 == 0) ? 1 : 0);
      @(negedge clk);
    end
    x_valid = 1'b0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
